// File: rtl/blit_pkg.sv
// Shared definitions for the sprite blitter.
//   blit_mode_e  : DRAW (sprite ROM) / FILL (solid colour)
//   blit_state_e : IDLE -> RUN -> FLUSH -> DONE -> IDLE
//   DEF_SCREEN_W/H : default visible screen size
//   COLOUR_WHITE : erase colour (erase = FILL with white)
//   cnt_w()      : counter width helper that never returns 0
package blit_pkg;

  typedef enum logic {
    MODE_DRAW = 1'b0,
    MODE_FILL = 1'b1
  } blit_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } blit_state_e;

  localparam int         DEF_SCREEN_W = 320;
  localparam int         DEF_SCREEN_H = 240;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  // A 1-entry range still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Pixel-side bus of the sprite blitter: sprite ROM read port plus the
// plot stream towards the vga_adapter.
//   master (blitter): drives rom_addr, out_x, out_y, out_colour, plot;
//                     samples rom_data (valid one cycle after rom_addr).
//   slave  (ROM/VGA): the mirror image.
interface sprite_blitter_if
  import blit_pkg::*;
#(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32
);
  localparam int A_W = cnt_w(SPR_W * SPR_H);

  logic [A_W-1:0]      rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [X_W-1:0]      out_x;
  logic [Y_W-1:0]      out_y;
  logic [COLOUR_W-1:0] out_colour;
  logic                plot;

  modport master (
    output rom_addr, out_x, out_y, out_colour, plot,
    input  rom_data
  );

  modport slave (
    input  rom_addr, out_x, out_y, out_colour, plot,
    output rom_data
  );

endinterface

// File: rtl/blit_counter.sv
// Raster counter for the sprite walk.
//   clear   : force cx=cy=0 (takes priority over advance)
//   advance : step one pixel in row-major order, wrapping at the sprite edge
//   cx, cy  : current sprite-relative pixel
//   last    : current pixel is (SPR_W-1, SPR_H-1)
module blit_counter
  import blit_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  localparam int CX_W = cnt_w(SPR_W),
  localparam int CY_W = cnt_w(SPR_H)
)(
  input  logic            clock,
  input  logic            resetn,
  input  logic            clear,
  input  logic            advance,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last
);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  logic            row_end;

  assign row_end = (cx_q == CX_W'(SPR_W - 1));
  assign last    = row_end && (cy_q == CY_W'(SPR_H - 1));

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (advance) begin
      if (row_end) begin
        cx_d = '0;
        // Wrap fully after the last pixel so the idle address reads 0.
        cy_d = last ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx = cx_q;
  assign cy = cy_q;

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks an SPR_W x SPR_H sprite in raster order, one pixel
// per cycle, and emits plot strokes at origin + offset.
//   clock, resetn : clock / async active-low reset
//   start         : request, honoured only in IDLE
//   mode          : 0 = DRAW (colour from sprite ROM, TRANSPARENT skipped),
//                   1 = FILL (fill_colour everywhere)
//   origin_x/y    : top-left of the blit, latched at start
//   fill_colour   : FILL colour, latched at start
//   pix           : ROM read port + plot stream (sprite_blitter_if.master)
//   busy, done    : busy in RUN/FLUSH/DONE; done pulses one cycle in DONE
// Optional feature: define BLIT_CLIP_EN to suppress plots whose unwrapped
// coordinate falls outside SCREEN_W x SCREEN_H. Cycle count is unchanged.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int                  X_W         = 9,
  parameter int                  Y_W         = 8,
  parameter int                  COLOUR_W    = 3,
  parameter int                  SPR_W       = 32,
  parameter int                  SPR_H       = 32,
  parameter int                  SCREEN_W    = DEF_SCREEN_W,
  parameter int                  SCREEN_H    = DEF_SCREEN_H,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = 3'b101
)(
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                mode,
  input  logic [X_W-1:0]      origin_x,
  input  logic [Y_W-1:0]      origin_y,
  input  logic [COLOUR_W-1:0] fill_colour,
  sprite_blitter_if.master    pix,
  output logic                busy,
  output logic                done
);

  localparam int CX_W = cnt_w(SPR_W);
  localparam int CY_W = cnt_w(SPR_H);
  localparam int A_W  = cnt_w(SPR_W * SPR_H);
  // Wide enough that origin + offset (offset < 256) never overflows,
  // so the clip compare sees the unwrapped coordinate.
  localparam int XS_W = X_W + 9;
  localparam int YS_W = Y_W + 9;

  blit_state_e         state_q, state_d;
  blit_mode_e          mode_q, mode_d;
  logic [X_W-1:0]      ox_q, ox_d;
  logic [Y_W-1:0]      oy_q, oy_d;
  logic [COLOUR_W-1:0] fill_q, fill_d;

  // Pixel stage: one register between address issue and plot.
  logic                vld_q, vld_d;
  logic                vis_q, vis_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;

  logic                cnt_clear, cnt_adv, cnt_last, run;
  logic [CX_W-1:0]     cx;
  logic [CY_W-1:0]     cy;
  logic [XS_W-1:0]     xs;
  logic [YS_W-1:0]     ys;
  logic                on_screen;

  blit_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_cnt (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .cx      (cx),
    .cy      (cy),
    .last    (cnt_last)
  );

  assign run          = (state_q == RUN);
  assign pix.rom_addr = A_W'(cy) * A_W'(SPR_W) + A_W'(cx);

  assign xs        = XS_W'(ox_q) + XS_W'(cx);
  assign ys        = YS_W'(oy_q) + YS_W'(cy);
  assign on_screen = (xs < XS_W'(SCREEN_W)) && (ys < YS_W'(SCREEN_H));

  // Control FSM and operand latch.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    fill_d    = fill_q;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_clear = 1'b1;
          mode_d    = blit_mode_e'(mode);
          ox_d      = origin_x;
          oy_d      = origin_y;
          fill_d    = fill_colour;
        end
      end
      RUN: begin
        cnt_adv = 1'b1;
        if (cnt_last) state_d = FLUSH;
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pixel stage: coordinates are modular in X_W / Y_W.
  always_comb begin
    vld_d = run;
    x_d   = run ? xs[X_W-1:0] : '0;
    y_d   = run ? ys[Y_W-1:0] : '0;
`ifdef BLIT_CLIP_EN
    vis_d = run && on_screen;
`else
    vis_d = run;
`endif
  end

`ifndef BLIT_CLIP_EN
  logic unused_clip;
  assign unused_clip = on_screen;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mode_q  <= MODE_DRAW;
      ox_q    <= '0;
      oy_q    <= '0;
      fill_q  <= '0;
      vld_q   <= 1'b0;
      vis_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      fill_q  <= fill_d;
      vld_q   <= vld_d;
      vis_q   <= vis_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // rom_data arrives in the same cycle as the staged coordinates, so the
  // colour and the transparency key are resolved combinationally here.
  always_comb begin
    pix.out_colour = '0;
    pix.plot       = 1'b0;
    if (vld_q) begin
      if (mode_q == MODE_FILL) begin
        pix.out_colour = fill_q;
        pix.plot       = vis_q;
      end else begin
        pix.out_colour = pix.rom_data;
        pix.plot       = vis_q && (pix.rom_data != TRANSPARENT);
      end
    end
  end

  assign pix.out_x = x_q;
  assign pix.out_y = y_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;
  import blit_pkg::*;

  logic       clock, resetn;
  logic       start_a, start_b, start_c;
  logic       mode;
  logic [8:0] origin_x;
  logic [7:0] origin_y;
  logic [2:0] fill_colour;
  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;

  logic [2:0] rom_b [16];

  int passed, total;
  int np, nd, dc, err, p, ux, uy;
  logic eplot;

  sprite_blitter_if #(.SPR_W(4),  .SPR_H(3))  if_a();
  sprite_blitter_if #(.SPR_W(4),  .SPR_H(4))  if_b();
  sprite_blitter_if #(.SPR_W(32), .SPR_H(32)) if_c();

  sprite_blitter #(.SPR_W(4), .SPR_H(3)) u_a (
    .clock(clock), .resetn(resetn), .start(start_a), .mode(mode),
    .origin_x(origin_x), .origin_y(origin_y), .fill_colour(fill_colour),
    .pix(if_a.master), .busy(busy_a), .done(done_a));

  sprite_blitter #(.SPR_W(4), .SPR_H(4)) u_b (
    .clock(clock), .resetn(resetn), .start(start_b), .mode(mode),
    .origin_x(origin_x), .origin_y(origin_y), .fill_colour(fill_colour),
    .pix(if_b.master), .busy(busy_b), .done(done_b));

  sprite_blitter #(.SPR_W(32), .SPR_H(32)) u_c (
    .clock(clock), .resetn(resetn), .start(start_c), .mode(mode),
    .origin_x(origin_x), .origin_y(origin_y), .fill_colour(fill_colour),
    .pix(if_c.master), .busy(busy_c), .done(done_c));

  // FILL-only instances see the key colour so any leak of rom_data shows.
  assign if_a.rom_data = 3'b101;
  assign if_c.rom_data = 3'b101;
  always @(posedge clock) if_b.rom_data <= rom_b[if_b.rom_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  initial begin
    passed = 0; total = 0;
    resetn = 1'b0; start_a = 0; start_b = 0; start_c = 0;
    mode = 0; origin_x = 0; origin_y = 0; fill_colour = 0;
    rom_b = '{3'd0, 3'd5, 3'd2, 3'd3, 3'd5, 3'd1, 3'd5, 3'd7,
              3'd0, 3'd1, 3'd2, 3'd5, 3'd4, 3'd6, 3'd7, 3'd5};
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_a", {if_a.plot, busy_a, done_a, if_a.out_x, if_a.out_y, if_a.out_colour, if_a.rom_addr}, 64'd0);
    chk("rst_b", {if_b.plot, busy_b, done_b, if_b.out_x, if_b.out_y, if_b.out_colour, if_b.rom_addr}, 64'd0);
    chk("rst_c", {if_c.plot, busy_c, done_c, if_c.out_x, if_c.out_y, if_c.out_colour, if_c.rom_addr}, 64'd0);
    resetn = 1'b1;
    @(negedge clock);

    // FILL 4x3 at (10,20) colour 1
    mode = 1; origin_x = 9'd10; origin_y = 8'd20; fill_colour = 3'b001; start_a = 1;
    @(negedge clock); start_a = 0;
    np = 0; nd = 0; dc = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clock);
      if (c == 1) chk("fill_busy", busy_a, 1);
      if (if_a.plot) begin
        chk("fill_pix", {if_a.out_x, if_a.out_y, if_a.out_colour, 12'(c)},
            {9'(10 + np % 4), 8'(20 + np / 4), 3'd1, 12'(np + 2)});
        np++;
      end
      if (done_a) begin nd++; dc = c; end
    end
    chk("fill_plots", np, 12);
    chk("fill_done_cyc", dc, 14);
    chk("fill_done_cnt", nd, 1);
    chk("fill_idle", busy_a, 0);

    // DRAW 4x4 at (50,60), five keyed ROM entries
    mode = 0; origin_x = 9'd50; origin_y = 8'd60; start_b = 1;
    @(negedge clock); start_b = 0;
    np = 0; nd = 0; dc = 0; err = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) @(negedge clock);
      if (c <= 16 && if_b.rom_addr !== 4'(c - 1)) err++;
      p = c - 2;
      if (p >= 0 && p < 16)
        chk("draw_pix", {if_b.plot, if_b.out_x, if_b.out_y, if_b.out_colour},
            {rom_b[p] != 3'b101, 9'(50 + p % 4), 8'(60 + p / 4), rom_b[p]});
      else if (if_b.plot) err++;
      if (if_b.plot) np++;
      if (done_b) begin nd++; dc = c; end
    end
    chk("draw_addr_err", err, 0);
    chk("draw_plots", np, 11);
    chk("draw_done_cyc", dc, 18);
    chk("draw_done_cnt", nd, 1);

    // FILL 32x32 at (300,230): clip or modular wrap
    mode = 1; origin_x = 9'd300; origin_y = 8'd230; fill_colour = 3'b010; start_c = 1;
    @(negedge clock); start_c = 0;
    np = 0; nd = 0; dc = 0; err = 0;
    for (int c = 1; c <= 1040; c++) begin
      if (c > 1) @(negedge clock);
      p = c - 2;
      if (p >= 0 && p < 1024) begin
        ux = 300 + p % 32;
        uy = 230 + p / 32;
`ifdef BLIT_CLIP_EN
        eplot = (ux < 320) && (uy < 240);
`else
        eplot = 1'b1;
`endif
        if (if_c.plot !== eplot) err++;
        if (if_c.plot && (if_c.out_x !== 9'(ux) || if_c.out_y !== 8'(uy) ||
                          if_c.out_colour !== 3'b010)) err++;
      end else if (if_c.plot) err++;
      if (if_c.plot) np++;
      if (done_c) begin nd++; dc = c; end
    end
    chk("big_pix_err", err, 0);
`ifdef BLIT_CLIP_EN
    chk("big_plots", np, 200);
`else
    chk("big_plots", np, 1024);
`endif
    chk("big_done_cyc", dc, 1026);
    chk("big_done_cnt", nd, 1);

    // start re-pulsed mid-RUN with a new origin/colour: must be ignored
    mode = 1; origin_x = 9'd10; origin_y = 8'd20; fill_colour = 3'b001; start_a = 1;
    @(negedge clock); start_a = 0;
    np = 0; nd = 0; dc = 0; err = 0;
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) @(negedge clock);
      if (if_a.plot) begin
        if ({if_a.out_x, if_a.out_y, if_a.out_colour} !==
            {9'(10 + np % 4), 8'(20 + np / 4), 3'd1}) err++;
        np++;
      end
      if (done_a) begin nd++; dc = c; end
      if (c == 5) begin
        origin_x = 9'd100; origin_y = 8'd100; fill_colour = COLOUR_WHITE; start_a = 1;
      end
      if (c == 6) start_a = 0;
    end
    chk("restart_coords", err, 0);
    chk("restart_plots", np, 12);
    chk("restart_done_cyc", dc, 14);
    chk("restart_done_cnt", nd, 1);

    // Reset at the 7th of 16 pixels, then a clean rerun
    mode = 1; origin_x = 9'd5; origin_y = 8'd7; fill_colour = 3'b011; start_b = 1;
    @(negedge clock); start_b = 0;
    np = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clock);
      if (if_b.plot) np++;
    end
    chk("abort_pre_plots", np, 7);
    resetn = 1'b0;
    #1;
    chk("abort_rst", {if_b.plot, busy_b, done_b, if_b.out_x, if_b.out_y, if_b.out_colour, if_b.rom_addr}, 64'd0);
    @(negedge clock); resetn = 1'b1;
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (done_b || busy_b || if_b.plot) nd++;
    end
    chk("abort_quiet", nd, 0);
    start_b = 1;
    @(negedge clock); start_b = 0;
    np = 0; nd = 0; dc = 0; err = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) @(negedge clock);
      if (if_b.plot) begin
        if ({if_b.out_x, if_b.out_y, if_b.out_colour} !==
            {9'(5 + np % 4), 8'(7 + np / 4), 3'b011}) err++;
        np++;
      end
      if (done_b) begin nd++; dc = c; end
    end
    chk("rerun_coords", err, 0);
    chk("rerun_plots", np, 16);
    chk("rerun_done_cyc", dc, 18);
    chk("rerun_done_cnt", nd, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
